// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status encodings and sequencer stages.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOV   = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_RMMOV  = 4'h4;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_MEMORY  = 3'd4,
      ST_WRBACK  = 3'd5,
      ST_PCUPD   = 3'd6,
      ST_HALT    = 3'd7
   } stage_e;

   // Instructions that need a data-memory access after EXECUTE
   function automatic logic uses_dmem(input logic [3:0] ic);
      return (ic == I_RMMOV) || (ic == I_MRMOV) || (ic == I_CALL) ||
             (ic == I_RET)   || (ic == I_PUSH)  || (ic == I_POP);
   endfunction

   // Of those, the ones that store to memory
   function automatic logic writes_dmem(input logic [3:0] ic);
      return (ic == I_RMMOV) || (ic == I_CALL) || (ic == I_PUSH);
   endfunction

endpackage

// File: rtl/seq_mem_wait.sv
// MEMORY-stage handshake resolver: counts wait cycles and decides completion or failure.
module seq_mem_wait
   import y86_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)(
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic dmem_ready,
   input  logic dmem_error,
   output logic done_ok,
   output logic done_fail
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

   logic [TW-1:0] wait_cnt;

   // Wait counter restarts at zero on every MEMORY entry and advances on each unready cycle
   always_ff @(posedge clk) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (!active)
         wait_cnt <= '0;
      else if (!dmem_ready)
         wait_cnt <= wait_cnt + 1'b1;
   end

   // A ready response always wins over a timeout landing in the same cycle
   assign done_ok   = active && dmem_ready && !dmem_error;
   assign done_fail = active && (dmem_ready ? dmem_error : (wait_cnt == LAST));

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle Y86 SEQ sequencer: one stage per clock, status tracking and retire/cycle counters.
module seq_stage_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   input  logic             imem_ready,
   input  logic             imem_error,
   input  logic             dmem_ready,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             execute_en,
   output logic             wb_en,
   output logic             pc_en,
   output logic             set_cc,
   output logic             mem_req,
   output logic             mem_write,
   output logic [2:0]       stat,
   output logic             busy,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   stage_e     state, state_nx;
   logic [2:0] stat_nx;
   logic [3:0] icode_q;
   logic       mem_ok, mem_fail;

   seq_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (state == ST_MEMORY),
      .dmem_ready (dmem_ready),
      .dmem_error (dmem_error),
      .done_ok    (mem_ok),
      .done_fail  (mem_fail)
   );

   // Stage sequencing and status resolution; errors and HLT all funnel into HALT
   always_comb begin
      state_nx = state;
      stat_nx  = stat;
      case (state)
         ST_IDLE:    if (start) state_nx = ST_FETCH;
         ST_FETCH: begin
            if (imem_ready) begin
               if (imem_error) begin
                  stat_nx  = STAT_ADR;
                  state_nx = ST_HALT;
               end else if (!instr_valid) begin
                  stat_nx  = STAT_INS;
                  state_nx = ST_HALT;
               end else if (icode == I_HALT) begin
                  stat_nx  = STAT_HLT;
                  state_nx = ST_HALT;
               end else begin
                  state_nx = ST_DECODE;
               end
            end
         end
         ST_DECODE:  state_nx = ST_EXECUTE;
         ST_EXECUTE: state_nx = uses_dmem(icode_q) ? ST_MEMORY : ST_WRBACK;
         ST_MEMORY: begin
            if (mem_ok) begin
               state_nx = ST_WRBACK;
            end else if (mem_fail) begin
               stat_nx  = STAT_ADR;
               state_nx = ST_HALT;
            end
         end
         ST_WRBACK:  state_nx = ST_PCUPD;
         ST_PCUPD:   state_nx = ST_FETCH;
         ST_HALT:    state_nx = ST_HALT;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Control state, status and counters; reset wins over any stage including a memory wait
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         stat        <= STAT_AOK;
         retired_cnt <= '0;
         cycle_cnt   <= '0;
      end else begin
         state <= state_nx;
         stat  <= stat_nx;
         if (busy)
            cycle_cnt <= cycle_cnt + 1'b1;
         if (state == ST_PCUPD)
            retired_cnt <= retired_cnt + 1'b1;
      end
   end

   // Instruction code is captured once per instruction when FETCH hands off to DECODE
   always_ff @(posedge clk) begin
      if (state == ST_FETCH && state_nx == ST_DECODE)
         icode_q <= icode;
   end

   assign fetch_en   = (state == ST_FETCH);
   assign decode_en  = (state == ST_DECODE);
   assign execute_en = (state == ST_EXECUTE);
   assign wb_en      = (state == ST_WRBACK);
   assign pc_en      = (state == ST_PCUPD);
   assign set_cc     = (state == ST_EXECUTE) && (icode_q == I_OPQ);
   assign mem_req    = (state == ST_MEMORY);
   assign mem_write  = mem_req && writes_dmem(icode_q);
   assign busy       = (state != ST_IDLE) && (state != ST_HALT);

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: stage-level reference model plus directed scenarios.
module tb_seq_stage_ctrl;

   localparam int CNT_W       = 32;
   localparam int MEM_TIMEOUT = 16;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DEC = 2, S_EXE = 3;
   localparam int S_MEM  = 4, S_WB    = 5, S_PC  = 6, S_HALT = 7;

   logic             clk = 1'b0;
   logic             rst_n, start, instr_valid, imem_ready, imem_error, dmem_ready, dmem_error;
   logic [3:0]       icode;
   logic             fetch_en, decode_en, execute_en, wb_en, pc_en, set_cc, mem_req, mem_write, busy;
   logic [2:0]       stat;
   logic [CNT_W-1:0] retired_cnt, cycle_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   int n_memreq = 0;
   int n_setcc  = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   seq_stage_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
      .imem_ready(imem_ready), .imem_error(imem_error), .dmem_ready(dmem_ready),
      .dmem_error(dmem_error), .fetch_en(fetch_en), .decode_en(decode_en),
      .execute_en(execute_en), .wb_en(wb_en), .pc_en(pc_en), .set_cc(set_cc),
      .mem_req(mem_req), .mem_write(mem_write), .stat(stat), .busy(busy),
      .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
   );

   // Reference model: which stage the instruction is in, driven by the stage rules
   int               m_st, m_wait;
   logic [3:0]       m_ic;
   logic [2:0]       m_stat;
   logic [CNT_W-1:0] m_ret, m_cyc;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_st   <= S_IDLE;
         m_stat <= 3'd1;
         m_ret  <= '0;
         m_cyc  <= '0;
         m_wait <= 0;
      end else begin
         if (m_st != S_IDLE && m_st != S_HALT) m_cyc <= m_cyc + 1'b1;
         case (m_st)
            S_IDLE:  if (start) m_st <= S_FETCH;
            S_FETCH: if (imem_ready) begin
               if (imem_error)          begin m_stat <= 3'd3; m_st <= S_HALT; end
               else if (!instr_valid)   begin m_stat <= 3'd4; m_st <= S_HALT; end
               else if (icode == 4'd0)  begin m_stat <= 3'd2; m_st <= S_HALT; end
               else                     begin m_ic <= icode; m_st <= S_DEC; end
            end
            S_DEC:   m_st <= S_EXE;
            S_EXE: begin
               m_wait <= 0;
               m_st   <= (m_ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (dmem_error) begin m_stat <= 3'd3; m_st <= S_HALT; end
                  else m_st <= S_WB;
               end else if (m_wait == MEM_TIMEOUT - 1) begin
                  m_stat <= 3'd3; m_st <= S_HALT;
               end else begin
                  m_wait <= m_wait + 1;
               end
            end
            S_WB:    m_st <= S_PC;
            S_PC:    begin m_ret <= m_ret + 1'b1; m_st <= S_FETCH; end
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: compare DUT against model on the falling edge, then return just after the rising edge
   task automatic tick();
      logic [8:0] exp_ctl, act_ctl;
      @(negedge clk);
      if (chk_on) begin
         exp_ctl = {m_st == S_FETCH, m_st == S_DEC, m_st == S_EXE, m_st == S_WB, m_st == S_PC,
                    (m_st == S_EXE) && (m_ic == 4'h6), m_st == S_MEM,
                    (m_st == S_MEM) && (m_ic inside {4'h4, 4'h8, 4'hA}),
                    (m_st != S_IDLE) && (m_st != S_HALT)};
         act_ctl = {fetch_en, decode_en, execute_en, wb_en, pc_en, set_cc, mem_req, mem_write, busy};
         chk("model_ctl", 64'(act_ctl), 64'(exp_ctl));
         chk("model_stat", 64'(stat), 64'(m_stat));
         chk("model_retired", 64'(retired_cnt), 64'(m_ret));
         chk("model_cycles", 64'(cycle_cnt), 64'(m_cyc));
      end
      if (mem_req) n_memreq++;
      if (set_cc)  n_setcc++;
      @(posedge clk);
      #1;
   endtask

   // Wait for a condition: 0 pc_en, 1 mem_req, 2 not busy
   task automatic wait_for(input int which, input int maxc, input string nm);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < maxc && !hit; i++) begin
         tick();
         case (which)
            0:       hit = pc_en;
            1:       hit = mem_req;
            default: hit = !busy;
         endcase
      end
      chk({nm, "_timeout"}, 64'(hit), 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; icode = 4'h1; instr_valid = 1'b1;
      imem_ready = 1'b0; imem_error = 1'b0; dmem_ready = 1'b0; dmem_error = 1'b0;
      tick();
      chk_on = 1'b1;
      tick();
      rst_n = 1'b1;
   endtask

   int base_mem, base_cc;
   logic [3:0] prog [6];

   initial begin
      // Reset state
      do_reset();
      chk("rst_stat", 64'(stat), 64'd1);
      chk("rst_retired", 64'(retired_cnt), 64'd0);
      chk("rst_cycles", 64'(cycle_cnt), 64'd0);
      chk("rst_outs", 64'({fetch_en, decode_en, execute_en, wb_en, pc_en, set_cc, mem_req, mem_write, busy}), 64'd0);

      // OPq: five stages, one set_cc pulse, no memory request
      do_reset();
      base_mem = n_memreq; base_cc = n_setcc;
      icode = 4'h6; imem_ready = 1'b1; start = 1'b1;
      wait_for(0, 20, "opq_pc");
      imem_ready = 1'b0; start = 1'b0;
      tick();
      chk("opq_retired", 64'(retired_cnt), 64'd1);
      chk("opq_cycles", 64'(cycle_cnt), 64'd5);
      chk("opq_setcc_cycles", 64'(n_setcc - base_cc), 64'd1);
      chk("opq_memreq_cycles", 64'(n_memreq - base_mem), 64'd0);

      // rmmovq with dmem_ready three cycles late
      do_reset();
      base_mem = n_memreq;
      icode = 4'h4; imem_ready = 1'b1; start = 1'b1;
      wait_for(1, 20, "rmmov_mem");
      chk("rmmov_write", 64'(mem_write), 64'd1);
      tick(); tick(); tick();
      dmem_ready = 1'b1;
      wait_for(0, 10, "rmmov_pc");
      imem_ready = 1'b0; dmem_ready = 1'b0; start = 1'b0;
      tick();
      chk("rmmov_memreq_cycles", 64'(n_memreq - base_mem), 64'd4);
      chk("rmmov_cycles", 64'(cycle_cnt), 64'd9);
      chk("rmmov_retired", 64'(retired_cnt), 64'd1);

      // mrmovq with no ready: timeout after 16 request cycles
      do_reset();
      base_mem = n_memreq;
      icode = 4'h5; imem_ready = 1'b1; start = 1'b1;
      wait_for(2, 60, "mrmov_halt");
      start = 1'b0;
      chk("mrmov_stat", 64'(stat), 64'd3);
      chk("mrmov_memreq_cycles", 64'(n_memreq - base_mem), 64'd16);
      chk("mrmov_retired", 64'(retired_cnt), 64'd0);
      chk("mrmov_cycles", 64'(cycle_cnt), 64'd19);

      // halt instruction, then a start pulse that must be ignored
      do_reset();
      icode = 4'h0; imem_ready = 1'b1; start = 1'b1;
      wait_for(2, 20, "hlt_halt");
      start = 1'b0;
      chk("hlt_stat", 64'(stat), 64'd2);
      chk("hlt_busy", 64'(busy), 64'd0);
      chk("hlt_retired", 64'(retired_cnt), 64'd0);
      tick(); start = 1'b1; tick(); tick(); start = 1'b0; tick();
      chk("hlt_ignore_start_stat", 64'(stat), 64'd2);
      chk("hlt_ignore_start_busy", 64'(busy), 64'd0);
      chk("hlt_cycles", 64'(cycle_cnt), 64'd1);

      // invalid instruction after two cycles of waiting in FETCH
      do_reset();
      icode = 4'h6; instr_valid = 1'b0; start = 1'b1;
      tick(); tick(); tick();
      chk("ins_fetch_hold", 64'(fetch_en), 64'd1);
      imem_ready = 1'b1;
      wait_for(2, 10, "ins_halt");
      start = 1'b0;
      chk("ins_stat", 64'(stat), 64'd4);
      chk("ins_cycles", 64'(cycle_cnt), 64'd3);

      // fetch address error beats invalid instruction
      do_reset();
      icode = 4'h6; instr_valid = 1'b0; imem_error = 1'b1; imem_ready = 1'b1; start = 1'b1;
      wait_for(2, 10, "iadr_halt");
      start = 1'b0;
      chk("iadr_stat", 64'(stat), 64'd3);

      // reset while a ret read is waiting in MEMORY
      do_reset();
      icode = 4'h9; imem_ready = 1'b1; start = 1'b1;
      wait_for(1, 20, "ret_mem");
      tick(); tick();
      chk("ret_memreq", 64'(mem_req), 64'd1);
      chk("ret_read", 64'(mem_write), 64'd0);
      rst_n = 1'b0; start = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rstmem_memreq", 64'(mem_req), 64'd0);
      chk("rstmem_stat", 64'(stat), 64'd1);
      chk("rstmem_counters", 64'({retired_cnt, cycle_cnt}), 64'd0);
      chk("rstmem_busy", 64'(busy), 64'd0);

      // call: ready arrives in the same cycle the timeout would fire
      do_reset();
      base_mem = n_memreq;
      icode = 4'h8; imem_ready = 1'b1; start = 1'b1;
      wait_for(1, 20, "call_mem");
      for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
      dmem_ready = 1'b1;
      wait_for(0, 10, "call_pc");
      imem_ready = 1'b0; dmem_ready = 1'b0; start = 1'b0;
      tick();
      chk("call_stat", 64'(stat), 64'd1);
      chk("call_retired", 64'(retired_cnt), 64'd1);
      chk("call_memreq_cycles", 64'(n_memreq - base_mem), 64'd16);

      // pop with a data-address error
      do_reset();
      icode = 4'hB; imem_ready = 1'b1; dmem_ready = 1'b1; dmem_error = 1'b1; start = 1'b1;
      wait_for(2, 20, "dadr_halt");
      start = 1'b0;
      chk("dadr_stat", 64'(stat), 64'd3);
      chk("dadr_cycles", 64'(cycle_cnt), 64'd4);

      // back-to-back program mixing memory and non-memory instructions
      do_reset();
      prog[0] = 4'h1; prog[1] = 4'h3; prog[2] = 4'h4; prog[3] = 4'h6; prog[4] = 4'h7; prog[5] = 4'h2;
      base_cc = n_setcc;
      icode = prog[0]; imem_ready = 1'b1; dmem_ready = 1'b1; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_for(0, 20, "prog_pc");
         if (i < 5) icode = prog[i + 1];
         else imem_ready = 1'b0;
      end
      start = 1'b0;
      tick();
      chk("prog_retired", 64'(retired_cnt), 64'd6);
      chk("prog_cycles", 64'(cycle_cnt), 64'd31);
      chk("prog_setcc_cycles", 64'(n_setcc - base_cc), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
